// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM main controller for the multicycle MIPS datapath
// Sequences fetch/decode/execute/memory/writeback, decodes Op/Funct into datapath
// selects and an ALU control code, and stretches FETCH/MEMRD/MEMWR by MEM_WAIT cycles.
// Optional feature macro: MC_JAL_EN (defined: JAL is executed via JALEX; undefined: JAL is illegal).
// Ports:
//   CLK, Reset      clock (rising edge), asynchronous active-high reset
//   Op, Funct, Zero instruction fields IR[31:26], IR[5:0] and ALU zero flag
//   PCEn, MemWrite, IRWrite, RegWrite   write enables (forced low while Reset is high)
//   IorD, AluSrcA, AluSrcB, ImmZeroExt, RegDst, MemToReg, PCSrc, AluCtl   datapath selects
//   IllegalOp       one-cycle pulse on an unsupported Op or Funct
//   State           current state, for debug
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic       ImmZeroExt,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [1:0] PCSrc,
    output logic [2:0] AluCtl,
    output logic       IllegalOp,
    output logic [3:0] State
);
    localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                           OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR = 3'b001, ALU_SLT = 3'b111;
`ifdef MC_JAL_EN
    localparam logic JAL_EN = 1'b1;
`else
    localparam logic JAL_EN = 1'b0;
`endif
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEX = 4'd8, ITYPEEX = 4'd9,
        ITYPEWB = 4'd10, JEX = 4'd11, JALEX = 4'd12
    } state_t;

    state_t          st;
    logic [CW-1:0]   cnt;
    logic            done, legal_op, legal_funct, pc_write, branch, ir_write, mem_write, reg_write;
    logic [2:0]      funct_ctl, imm_ctl;

    // The wait counter only runs in FETCH/MEMRD/MEMWR; it is zero in every other state.
    assign done        = cnt == CW'(MEM_WAIT);
    assign legal_op    = Op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI,
                                    OP_ANDI, OP_ORI, OP_SLTI, OP_J} || (JAL_EN && Op == OP_JAL);
    assign legal_funct = Funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign funct_ctl   = Funct == 6'b100010 ? ALU_SUB :
                         Funct == 6'b100100 ? ALU_AND :
                         Funct == 6'b100101 ? ALU_OR  :
                         Funct == 6'b101010 ? ALU_SLT : ALU_ADD;
    assign imm_ctl     = Op == OP_ANDI ? ALU_AND :
                         Op == OP_ORI  ? ALU_OR  :
                         Op == OP_SLTI ? ALU_SLT : ALU_ADD;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            cnt <= '0;
            case (st)
                FETCH:   if (done) st <= DECODE; else cnt <= cnt + 1'b1;
                DECODE:
                    case (Op)
                        OP_LW, OP_SW:                     st <= MEMADR;
                        OP_RTYPE:                         st <= RTYPEEX;
                        OP_BEQ, OP_BNE:                   st <= BEX;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: st <= ITYPEEX;
                        OP_J:                             st <= JEX;
`ifdef MC_JAL_EN
                        OP_JAL:                           st <= JALEX;
`endif
                        default:                          st <= FETCH;
                    endcase
                MEMADR:  st <= (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (done) st <= MEMWB; else cnt <= cnt + 1'b1;
                MEMWR:   if (done) st <= FETCH; else cnt <= cnt + 1'b1;
                RTYPEEX: st <= legal_funct ? RTYPEWB : FETCH;
                ITYPEEX: st <= ITYPEWB;
                default: st <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        IorD       = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        ImmZeroExt = 1'b0;
        RegDst     = 2'b00;
        MemToReg   = 2'b00;
        PCSrc      = 2'b00;
        AluCtl     = ALU_ADD;
        IllegalOp  = 1'b0;
        case (st)
            FETCH:   begin AluSrcB = 2'b01; ir_write = done; pc_write = done; end
            DECODE:  begin AluSrcB = 2'b11; IllegalOp = !legal_op; end
            MEMADR:  begin AluSrcA = 1'b1; AluSrcB = 2'b10; end
            MEMRD:   IorD = 1'b1;
            MEMWB:   begin MemToReg = 2'b01; reg_write = 1'b1; end
            MEMWR:   begin IorD = 1'b1; mem_write = done; end
            RTYPEEX: begin AluSrcA = 1'b1; AluCtl = funct_ctl; IllegalOp = !legal_funct; end
            RTYPEWB: begin RegDst = 2'b01; reg_write = 1'b1; end
            BEX:     begin AluSrcA = 1'b1; AluCtl = ALU_SUB; PCSrc = 2'b01; branch = 1'b1; end
            ITYPEEX: begin
                AluSrcA    = 1'b1;
                AluSrcB    = 2'b10;
                AluCtl     = imm_ctl;
                ImmZeroExt = Op == OP_ANDI || Op == OP_ORI;
            end
            ITYPEWB: reg_write = 1'b1;
            JEX:     begin PCSrc = 2'b10; pc_write = 1'b1; end
`ifdef MC_JAL_EN
            // PC already holds PC+4 here, so it is written to $31 while the jump is taken.
            JALEX:   begin
                PCSrc     = 2'b10;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                RegDst    = 2'b10;
                MemToReg  = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    // Write enables are masked by Reset so nothing is written in the cycle it rises.
    assign PCEn     = !Reset && (pc_write || (branch && (Zero ^ (Op == OP_BNE))));
    assign IRWrite  = !Reset && ir_write;
    assign MemWrite = !Reset && mem_write;
    assign RegWrite = !Reset && reg_write;
    assign State    = st;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl at MEM_WAIT 0, 2 and 3
module tb_multicycle_ctrl;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                           OP_J = 6'b000010, OP_JAL = 6'b000011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, memwrite, irwrite, regwrite, iord, srca;
        logic [1:0] srcb;
        logic       zext;
        logic [1:0] regdst, memtoreg, pcsrc;
        logic [2:0] aluctl;
        logic       ill;
    } rec_t;

    logic clk = 1'b0;
    int   tests = 0, fails = 0, ndone = 0;

    always #5 clk = ~clk;

    function automatic rec_t blank(logic [3:0] s);
        rec_t b;
        b        = '0;
        b.st     = s;
        b.aluctl = 3'b010;
        return b;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        logic [5:0] op, funct;
        logic       zero, rst;
        logic       PCEn, MemWrite, IRWrite, RegWrite, IorD, AluSrcA, ImmZeroExt, IllegalOp;
        logic [1:0] AluSrcB, RegDst, MemToReg, PCSrc;
        logic [2:0] AluCtl;
        logic [3:0] State;
        rec_t       act, rrec;
        rec_t       q[$];
        logic [5:0] ops[11] = '{OP_LW, OP_SW, OP_RT, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                                OP_ORI, OP_SLTI, OP_J, OP_JAL};
        logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        multicycle_ctrl #(.MEM_WAIT(W)) dut (
            .CLK(clk), .Reset(rst), .Op(op), .Funct(funct), .Zero(zero),
            .PCEn(PCEn), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
            .IorD(IorD), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ImmZeroExt(ImmZeroExt),
            .RegDst(RegDst), .MemToReg(MemToReg), .PCSrc(PCSrc), .AluCtl(AluCtl),
            .IllegalOp(IllegalOp), .State(State)
        );

        assign act = {State, PCEn, MemWrite, IRWrite, RegWrite, IorD, AluSrcA, AluSrcB,
                      ImmZeroExt, RegDst, MemToReg, PCSrc, AluCtl, IllegalOp};

        task automatic chk(input string nm, input int cyc, input rec_t e);
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL w%0d %s cycle %0d op=%b funct=%b: got st=%0d sig=%h, want st=%0d sig=%h",
                         W, nm, cyc, op, funct, act.st, act[18:0], e.st, e[18:0]);
            end
        endtask

        task automatic pin(input string nm, input int got, input int want);
            tests++;
            if (got != want) begin
                fails++;
                $display("FAIL w%0d model %s: got %0d want %0d", W, nm, got, want);
            end
        endtask

        task automatic phase(input rec_t r, input rec_t f, input int n);
            for (int j = 0; j < n - 1; j++) q.push_back(r);
            q.push_back(f);
        endtask

        // Expected per-cycle trace of one instruction, built phase by phase from the
        // instruction class; memory phases last W+1 cycles with strobes on the last one.
        task automatic build(input logic [5:0] o, input logic [5:0] fn, input logic z);
            rec_t r, f;
            q.delete();
            r = blank(0); r.srcb = 2'b01;
            f = r; f.irwrite = 1'b1; f.pcen = 1'b1;
            phase(r, f, W + 1);
            r = blank(1); r.srcb = 2'b11;
            if (o == OP_LW || o == OP_SW) begin
                phase(r, r, 1);
                r = blank(2); r.srca = 1'b1; r.srcb = 2'b10;
                phase(r, r, 1);
                if (o == OP_LW) begin
                    r = blank(3); r.iord = 1'b1;
                    phase(r, r, W + 1);
                    r = blank(4); r.memtoreg = 2'b01; r.regwrite = 1'b1;
                    phase(r, r, 1);
                end else begin
                    r = blank(5); r.iord = 1'b1;
                    f = r; f.memwrite = 1'b1;
                    phase(r, f, W + 1);
                end
            end else if (o == OP_RT) begin
                phase(r, r, 1);
                r = blank(6); r.srca = 1'b1;
                case (fn)
                    6'b100000: r.aluctl = 3'b010;
                    6'b100010: r.aluctl = 3'b110;
                    6'b100100: r.aluctl = 3'b000;
                    6'b100101: r.aluctl = 3'b001;
                    6'b101010: r.aluctl = 3'b111;
                    default:   r.ill = 1'b1;
                endcase
                phase(r, r, 1);
                if (!r.ill) begin
                    r = blank(7); r.regdst = 2'b01; r.regwrite = 1'b1;
                    phase(r, r, 1);
                end
            end else if (o == OP_BEQ || o == OP_BNE) begin
                phase(r, r, 1);
                r = blank(8); r.srca = 1'b1; r.aluctl = 3'b110; r.pcsrc = 2'b01;
                r.pcen = (o == OP_BNE) ? !z : z;
                phase(r, r, 1);
            end else if (o == OP_ADDI || o == OP_ANDI || o == OP_ORI || o == OP_SLTI) begin
                phase(r, r, 1);
                r = blank(9); r.srca = 1'b1; r.srcb = 2'b10;
                r.aluctl = o == OP_ANDI ? 3'b000 : o == OP_ORI ? 3'b001 : o == OP_SLTI ? 3'b111 : 3'b010;
                r.zext = o == OP_ANDI || o == OP_ORI;
                phase(r, r, 1);
                r = blank(10); r.regwrite = 1'b1;
                phase(r, r, 1);
            end else if (o == OP_J) begin
                phase(r, r, 1);
                r = blank(11); r.pcsrc = 2'b10; r.pcen = 1'b1;
                phase(r, r, 1);
`ifdef MC_JAL_EN
            end else if (o == OP_JAL) begin
                phase(r, r, 1);
                r = blank(12); r.pcsrc = 2'b10; r.pcen = 1'b1; r.regwrite = 1'b1;
                r.regdst = 2'b10; r.memtoreg = 2'b10;
                phase(r, r, 1);
`endif
            end else begin
                r.ill = 1'b1;
                phase(r, r, 1);
            end
        endtask

        // Entered at posedge+1 of the first FETCH cycle; returns at posedge+1 of the next one.
        task automatic run(input logic [5:0] o, input logic [5:0] fn, input logic z, input logic ab);
            int k;
            op = o; funct = fn; zero = z;
            build(o, fn, z);
            k = W + 3 + $urandom_range(0, W);
            for (int i = 0; i < q.size(); i++) begin
                if (ab && o == OP_LW && i == k) begin
                    rst = 1'b1;
                    #1 chk("reset_rise", i, rrec);
                    @(negedge clk) chk("reset_hold", i, rrec);
                    @(posedge clk);
                    #1 chk("reset_edge", i, rrec);
                    rst = 1'b0;
                    return;
                end
                @(negedge clk) chk("trace", i, q[i]);
                @(posedge clk);
                #1;
            end
        endtask

        initial begin
            rrec = blank(0); rrec.srcb = 2'b01;
            rst = 1'b1; op = '0; funct = '0; zero = 1'b0;
            build(OP_LW, 6'd0, 1'b0);
            pin("lw_len", q.size(), 5 + 2 * W);
            pin("lw_fetch_ir", int'(q[W].irwrite), 1);
            pin("lw_last_state", int'(q[q.size() - 1].st), 4);
            build(OP_SW, 6'd0, 1'b0);
            pin("sw_len", q.size(), 4 + 2 * W);
            pin("sw_last_memwrite", int'(q[q.size() - 1].memwrite), 1);
            build(OP_RT, 6'b101010, 1'b0);
            pin("rtype_len", q.size(), 4 + W);
            pin("slt_ctl", int'(q[W + 2].aluctl), 7);
            build(OP_BNE, 6'd0, 1'b0);
            pin("bne_len", q.size(), 3 + W);
            pin("bne_z0_pcen", int'(q[W + 2].pcen), 1);
            build(6'b111111, 6'd0, 1'b0);
            pin("illegal_len", q.size(), 2 + W);
            @(negedge clk) chk("reset_start", 0, rrec);
            @(posedge clk);
            #1 rst = 1'b0;
            run(OP_LW, 6'd0, 1'b0, 1'b0);
            run(OP_SW, 6'd0, 1'b1, 1'b0);
            run(OP_BEQ, 6'd0, 1'b1, 1'b0);
            run(OP_BEQ, 6'd0, 1'b0, 1'b0);
            run(OP_BNE, 6'd0, 1'b1, 1'b0);
            run(OP_BNE, 6'd0, 1'b0, 1'b0);
            run(OP_RT, 6'b101010, 1'b0, 1'b0);
            run(OP_RT, 6'b000011, 1'b0, 1'b0);
            run(OP_ORI, 6'd0, 1'b0, 1'b0);
            run(OP_JAL, 6'd0, 1'b0, 1'b0);
            run(OP_LW, 6'd0, 1'b0, 1'b1);
            run(OP_ANDI, 6'd0, 1'b0, 1'b0);
            run(OP_SLTI, 6'd0, 1'b0, 1'b0);
            run(OP_ADDI, 6'd0, 1'b0, 1'b0);
            run(OP_J, 6'd0, 1'b0, 1'b0);
            run(6'b111111, 6'd0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) run(OP_RT, functs[i], 1'b0, 1'b0);
            repeat (80) begin
                int oi, fi;
                logic [5:0] ro, rf;
                oi = $urandom_range(0, 12);
                fi = $urandom_range(0, 6);
                ro = (oi < 11) ? ops[oi] : 6'($urandom);
                rf = (fi < 5) ? functs[fi] : 6'($urandom);
                run(ro, rf, 1'($urandom), $urandom_range(0, 3) == 0);
            end
            ndone++;
        end
    end

    initial begin
        fork
            wait (ndone == 3);
            #200000;
        join_any
        disable fork;
        if (ndone != 3) begin
            fails++;
            $display("FAIL timeout: got %0d instances done, want 3", ndone);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
